// File: rtl/baopoco_quant_gain_pkg.sv
// Shared definitions for the quant1_gain coefficient sequencer: command opcodes,
// sequencer states and bit positions within the command and status words.
package baopoco_quant_gain_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_FILL  = 2'b01,
    OP_SWAP  = 2'b10,
    OP_NOP   = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL,
    ST_SWAP_WAIT
  } state_t;

  localparam int CMD_TOGGLE_BIT = 31;
  localparam int CMD_OP_LSB     = 29;
  localparam int CMD_ADDR_LSB   = 16;

  localparam int STATUS_BUSY_BIT    = 31;
  localparam int STATUS_BANK_BIT    = 30;
  localparam int STATUS_ARMED_BIT   = 29;
  localparam int STATUS_DROPPED_BIT = 28;
  localparam int STATUS_COUNT_LSB   = 0;
  localparam int STATUS_COUNT_W     = 8;

endpackage

// File: rtl/baopoco_toggle_detect.sv
// Registers the software command word and emits a one-cycle new_cmd pulse each
// time its toggle bit changes level.
module baopoco_toggle_detect
  import baopoco_quant_gain_pkg::*;
(
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] cmd_reg,
  output logic [31:0] cmd_q,
  output logic        new_cmd
);

  logic tog_seen;

  // NOTE: sequential state is always assigned with <= so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      // Loading the live toggle level keeps a level held through reset from
      // looking like a fresh command once reset is released.
      cmd_q    <= cmd_reg;
      tog_seen <= cmd_reg[CMD_TOGGLE_BIT];
    end else begin
      cmd_q    <= cmd_reg;
      tog_seen <= cmd_q[CMD_TOGGLE_BIT];
    end
  end

  assign new_cmd = cmd_q[CMD_TOGGLE_BIT] ^ tog_seen;

endmodule

// File: rtl/baopoco_quant_gain_ctrl.sv
// Command sequencer driving the write port of the double-buffered quantizer gain
// BRAM; bank swaps land only on sync_in. Define QUANT_GAIN_AUTOSWAP_EN to arm a
// swap automatically after every WRITE or FILL.
module baopoco_quant_gain_ctrl
  import baopoco_quant_gain_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int GAIN_W = 16
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       cmd_reg,
  input  logic              sync_in,
  output logic              coef_we,
  output logic [ADDR_W:0]   coef_addr,
  output logic [GAIN_W-1:0] coef_data,
  output logic              bank_sel,
  output logic [31:0]       status
);

`ifdef QUANT_GAIN_AUTOSWAP_EN
  localparam state_t DONE_STATE = ST_SWAP_WAIT;
`else
  localparam state_t DONE_STATE = ST_IDLE;
`endif

  logic [31:0]       cmd_q;
  logic              new_cmd;
  opcode_t           cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_unused;
  logic              last_addr;
  logic              busy;

  state_t            state;
  logic              dropped;
  logic [7:0]        cmd_count;

  baopoco_toggle_detect u_toggle_detect (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .cmd_reg  (cmd_reg),
    .cmd_q    (cmd_q),
    .new_cmd  (new_cmd)
  );

  assign cmd_op     = opcode_t'(cmd_q[CMD_OP_LSB +: 2]);
  assign cmd_addr   = cmd_q[CMD_ADDR_LSB +: ADDR_W];
  // Reserved bit 28 and address/gain bits beyond the configured widths are ignored.
  assign cmd_unused = ^cmd_q;
  assign last_addr  = &coef_addr[ADDR_W-1:0];
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state     <= ST_IDLE;
      coef_we   <= 1'b0;
      coef_addr <= '0;
      coef_data <= '0;
      bank_sel  <= 1'b0;
      dropped   <= 1'b0;
      cmd_count <= '0;
    end else begin
      if (new_cmd && busy) begin
        dropped <= 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (new_cmd) begin
            cmd_count <= cmd_count + 8'd1;
            case (cmd_op)
              OP_WRITE: begin
                state     <= ST_WRITE;
                coef_we   <= 1'b1;
                coef_addr <= {~bank_sel, cmd_addr};
                coef_data <= cmd_q[GAIN_W-1:0];
              end
              OP_FILL: begin
                state     <= ST_FILL;
                coef_we   <= 1'b1;
                coef_addr <= {~bank_sel, {ADDR_W{1'b0}}};
                coef_data <= cmd_q[GAIN_W-1:0];
              end
              OP_SWAP: begin
                // A sync coincident with acceptance is deliberately not seen here.
                state <= ST_SWAP_WAIT;
              end
              default: begin
              end
            endcase
          end
        end

        ST_WRITE: begin
          coef_we <= 1'b0;
          state   <= DONE_STATE;
        end

        ST_FILL: begin
          // coef_addr doubles as the fill counter; the bank bit cannot move mid-fill.
          if (last_addr) begin
            coef_we <= 1'b0;
            state   <= DONE_STATE;
          end else begin
            coef_addr[ADDR_W-1:0] <= coef_addr[ADDR_W-1:0] + ADDR_W'(1);
          end
        end

        ST_SWAP_WAIT: begin
          if (sync_in) begin
            bank_sel <= ~bank_sel;
            state    <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every signal written in always_comb gets a full default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    status                                        = '0;
    status[STATUS_BUSY_BIT]                       = busy;
    status[STATUS_BANK_BIT]                       = bank_sel;
    status[STATUS_ARMED_BIT]                      = (state == ST_SWAP_WAIT);
    status[STATUS_DROPPED_BIT]                    = dropped;
    status[STATUS_COUNT_LSB +: STATUS_COUNT_W]    = cmd_count;
  end

endmodule

// File: tb/tb_baopoco_quant_gain_ctrl.sv
// Directed bench for baopoco_quant_gain_ctrl (ADDR_W=4): table of single commands
// plus hand-written swap, dropped-command and reset sequences.
module tb_baopoco_quant_gain_ctrl;
  import baopoco_quant_gain_pkg::*;

  localparam int ADDR_W = 4;
  localparam int GAIN_W = 16;

  logic              clk;
  logic              rst;
  logic [31:0]       cmd_reg;
  logic              sync_in;
  logic              coef_we;
  logic [ADDR_W:0]   coef_addr;
  logic [GAIN_W-1:0] coef_data;
  logic              bank_sel;
  logic [31:0]       status;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic tog      = 1'b0;
  logic exp_bank = 1'b0;

  typedef struct {
    opcode_t     op;
    logic [11:0] addr;
    logic [15:0] gain;
    int          exp_writes;
    logic [4:0]  exp_first;
    int          exp_busy;
    logic [7:0]  exp_count;
  } vec_t;

  vec_t vecs[5];

  baopoco_quant_gain_ctrl #(.ADDR_W(ADDR_W), .GAIN_W(GAIN_W)) dut (
    .user_clk  (clk),
    .user_rst  (rst),
    .cmd_reg   (cmd_reg),
    .sync_in   (sync_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .bank_sel  (bank_sel),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic issue(input opcode_t op, input logic [11:0] addr, input logic [15:0] gain);
    tog     = ~tog;
    cmd_reg = {tog, op, 1'b0, addr, gain};
  endtask

  task automatic pulse_sync();
    sync_in = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int         writes, busy_cyc, first_cyc, order_err, data_err;
    logic [4:0] first_addr;
    writes = 0; busy_cyc = 0; first_cyc = -1; order_err = 0; data_err = 0;
    first_addr = '0;
    issue(v.op, v.addr, v.gain);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (status[31]) busy_cyc++;
      if (coef_we) begin
        if (writes == 0) begin
          first_addr = coef_addr;
          first_cyc  = c;
        end else if (coef_addr != 5'(first_addr + writes)) begin
          order_err++;
        end
        if (coef_data != v.gain) data_err++;
        writes++;
      end
    end
    check("write_count", writes, v.exp_writes);
    if (v.exp_writes > 0) begin
      check("first_addr", first_addr, v.exp_first);
      check("latency", first_cyc, 2);
    end
    check("addr_order", order_err, 0);
    check("write_data", data_err, 0);
    check("busy_cycles", busy_cyc, v.exp_busy);
    check("cmd_count", status[7:0], v.exp_count);
    check("bank_sel", bank_sel, exp_bank);
  endtask

  initial begin
    int writes, data_err, busy_cyc;

    vecs[0] = '{OP_WRITE, 12'h005, 16'h1234, 1,  5'h15, 1,  8'd1};
    vecs[1] = '{OP_WRITE, 12'hFF3, 16'hBEEF, 1,  5'h13, 1,  8'd2};
    vecs[2] = '{OP_NOP,   12'h00A, 16'hFFFF, 0,  5'h00, 0,  8'd3};
    vecs[3] = '{OP_FILL,  12'h007, 16'h00FF, 16, 5'h10, 16, 8'd4};
    vecs[4] = '{OP_WRITE, 12'h00F, 16'h0001, 1,  5'h1F, 1,  8'd5};

    // Reset with the toggle bit held high.
    rst     = 1'b1;
    sync_in = 1'b0;
    tog     = 1'b1;
    cmd_reg = 32'h8005_1234;
    repeat (3) @(negedge clk);
    check("rst_coef_we", coef_we, 0);
    check("rst_coef_addr", coef_addr, 0);
    check("rst_coef_data", coef_data, 0);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_status", status, 0);
    rst = 1'b0;
    writes = 0;
    repeat (6) begin
      @(negedge clk);
      if (coef_we) writes++;
    end
    check("held_toggle_writes", writes, 0);
    check("held_toggle_status", status, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // A sync while idle must not touch the bank.
    pulse_sync();
    check("idle_sync_bank", bank_sel, 0);

    // Explicit swap, sync five cycles after acceptance.
    issue(OP_SWAP, 12'h000, 16'h0000);
    repeat (2) @(negedge clk);
    check("swap_armed", status[29], 1);
    check("swap_busy", status[31], 1);
    repeat (4) @(negedge clk);
    check("swap_wait_bank", bank_sel, 0);
    pulse_sync();
    exp_bank = 1'b1;
    check("swap_bank", bank_sel, 1);
    check("swap_status_bank", status[30], 1);
    check("swap_disarmed", status[29], 0);
    check("swap_idle", status[31], 0);
    check("swap_count", status[7:0], 6);

    run_vec('{OP_WRITE, 12'h002, 16'hCAFE, 1, 5'h02, 1, 8'd7});

    // Command arriving mid-FILL is dropped; captured gain survives cmd_reg change.
    issue(OP_FILL, 12'h000, 16'hA5A5);
    writes = 0; data_err = 0; busy_cyc = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (status[31]) busy_cyc++;
      if (coef_we) begin
        if (writes == 0) check("drop_first_addr", coef_addr, 5'h00);
        if (coef_data != 16'hA5A5) data_err++;
        writes++;
      end
      if (c == 4) issue(OP_WRITE, 12'h009, 16'h5555);
    end
    check("drop_writes", writes, 16);
    check("drop_data", data_err, 0);
    check("drop_busy", busy_cyc, 16);
    check("dropped", status[28], 1);
    check("drop_count", status[7:0], 8);

    // Reset in the middle of a FILL while bank 1 is live.
    issue(OP_FILL, 12'h000, 16'h0F0F);
    repeat (5) @(negedge clk);
    check("midfill_we", coef_we, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midfill_rst_we", coef_we, 0);
    check("midfill_rst_bank", bank_sel, 0);
    check("midfill_rst_status", status, 0);
    rst = 1'b0;
    exp_bank = 1'b0;
    writes = 0;
    repeat (4) begin
      @(negedge clk);
      if (coef_we) writes++;
    end
    check("post_rst_writes", writes, 0);

    // Sync coincident with SWAP acceptance is ignored; the next one swaps.
    issue(OP_SWAP, 12'h000, 16'h0000);
    @(negedge clk);
    sync_in = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
    check("coinc_bank", bank_sel, 0);
    check("coinc_armed", status[29], 1);
    repeat (3) @(negedge clk);
    pulse_sync();
    check("coinc_next_bank", bank_sel, 1);
    check("coinc_disarmed", status[29], 0);
    check("coinc_count", status[7:0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/baopoco_quant_gain_ctrl.md
# baopoco_quant_gain_ctrl

Sequencer for the quantizer gain coefficient memory behind the `quant1_gain` software register. It decodes toggle-strobed commands that software writes to the 32-bit register and drives the write port of a double-buffered per-channel gain BRAM. All writes land in the inactive bank; bank swaps take effect only on a spectrum sync, so gains never change mid-spectrum. It lives in the user (DSP) clock domain, between the ppc2simulink register output and the quantizer.

## Interface
- `ADDR_W`, 11: channel address width; legal range 1..12.
- `GAIN_W`, 16: gain word width; legal range 1..16.
- `user_clk`  in  1: DSP clock; the only clock.
- `user_rst`  in  1: reset; synchronous, active-high.
- `cmd_reg`  in  32: command word from the `quant1_gain` register.
  - [31] toggle strobe.
  - [30:29] opcode.
  - [27:16] channel address.
  - [15:0] gain.
- `sync_in`  in  1: one-cycle spectrum-start pulse.
- `coef_we`  out  1: coefficient BRAM write enable.
- `coef_addr`  out  ADDR_W+1: BRAM address; the MSB selects the bank.
- `coef_data`  out  GAIN_W: BRAM write data, taken from `cmd_reg[GAIN_W-1:0]`.
- `bank_sel`  out  1: bank the quantizer currently reads.
- `status`  out  32: readback word for a simulink2ppc register.
  - [31] busy.
  - [30] bank_sel.
  - [29] swap_armed.
  - [28] dropped (sticky).
  - [7:0] cmd_count.
  - All other bits are 0.

## Operation
- **Command detection:** a new command exists when `cmd_reg[31]` differs from the internal `tog_seen` bit. On acceptance `tog_seen` takes the new value.
- **Opcodes:**
  - 00 WRITE: one write to `{~bank_sel, addr}`.
  - 01 FILL: write the gain to every address 0..2^ADDR_W-1 of the inactive bank.
  - 10 SWAP: arm a bank swap for the next sync.
  - 11 NOP: counted, no other action.
- **States:** IDLE, WRITE, FILL, SWAP_WAIT.
  - IDLE → WRITE / FILL / SWAP_WAIT according to the opcode of an accepted command.
  - WRITE → IDLE after 1 cycle.
  - FILL → IDLE after the write to the last address.
  - SWAP_WAIT → IDLE on the cycle `sync_in` is sampled high; `bank_sel` toggles on that edge.
- **Command capture:** the gain and address are latched at acceptance. Later changes to `cmd_reg` during FILL do not alter the data being written.
- **Busy:** high in every state except IDLE.
- **Commands while busy:** the toggle is consumed (`tog_seen` updated), no action is taken, and `dropped` is set. `dropped` clears only on reset.
- **cmd_count:** counts accepted (non-dropped) commands, 8 bits, wraps 255→0.
- **Address field:** bits of [27:16] above ADDR_W are ignored.

## Timing
- **Reset values:**
  - `coef_we`=0, `coef_addr`=0, `coef_data`=0.
  - `bank_sel`=0, `status`=0, state=IDLE.
  - During reset, `tog_seen` loads `cmd_reg[31]`, so a toggle level held through reset is not treated as a command.
- **Input register:** `cmd_reg` is registered once (`cmd_q`), and detection compares `cmd_q[31]`.
- **Latency:** toggle change on the input at edge n → `cmd_q` at n+1 → accepted at n+2 → first `coef_we` high in the cycle after edge n+2.
- **FILL:** exactly 2^ADDR_W consecutive `coef_we` cycles, addresses ascending, then IDLE.
- **Sync during acceptance:** a `sync_in` in the same cycle a SWAP is accepted does not swap; the swap waits for the next sync.
- **Sync in other states:** `sync_in` is ignored outside SWAP_WAIT.
- **Back-to-back commands:** a new command can be accepted on the cycle after the return to IDLE.
- **Reset mid-FILL or mid-SWAP_WAIT:** the operation aborts immediately and `bank_sel` returns to 0.

## Configuration
- `QUANT_GAIN_AUTOSWAP_EN`:
  - Defined: completing a WRITE or a FILL enters SWAP_WAIT directly, so staged gains go live at the next sync without a SWAP command. `busy` stays high until the swap occurs.
  - Undefined: swaps occur only on an explicit SWAP command.

## Structure
- **Shared package `baopoco_quant_gain_pkg`:** opcode constants, state enum, `status` bit-position constants.
- **Sub-module `baopoco_toggle_detect`:** input register, `tog_seen` with reset load, one-cycle `new_cmd` pulse.
- **Top:** state machine, FILL address counter, bank register, status.

## Test plan
- **Single write:** reset; `cmd_reg`=0x0005_1234 with toggle flipped (bit 31 = 1) → one `coef_we` pulse, `coef_addr`=0x805 (bank 1, since `bank_sel`=0), `coef_data`=0x1234, `cmd_count`=1.
- **Fill with ADDR_W=4:** FILL gain 0x00FF → 16 consecutive writes to addresses 0x10..0x1F with data 0x00FF; `busy` high for exactly 16 cycles.
- **Swap timing:** SWAP accepted, then `sync_in` pulsed 5 cycles later → `bank_sel` 0→1 in the cycle after the sync; `swap_armed` clears.
- **Coincident sync:** `sync_in` in the same cycle the SWAP is accepted → no toggle; the swap happens on the following sync.
- **Dropped command:** a toggle during FILL → no extra writes, `dropped`=1, `cmd_count` unchanged.
- **Reset behaviour:** reset asserted with bit 31 = 1 → no command after release. Reset mid-FILL → `coef_we`=0 in the next cycle, `bank_sel`=0.
